vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Shares one single-port synchronous framebuffer RAM between the VGA display fetch and a pixel-write requester such as a drawing engine or CPU bridge. It sits between the 640x480 timing generator (`p_tick`, `x`, `y`, `video_on`) and the RAM. Display reads are scheduled ahead of need and always win arbitration. Writes use the remaining RAM cycles through a valid/ready handshake. The output is a registered RGB pixel stream, upscaled from a 160x120 framebuffer.

## Interface
- `FB_W`, 160: framebuffer width in words.
- `FB_H`, 120: framebuffer height in words.
- `SCALE_SHIFT`, 2: each framebuffer word covers 2^S x 2^S screen pixels.
- `HD`, 640; `VD`, 480; `VMAX`, 524: display width, display height, and last line index.
- `PIX_W`, 12: RGB word width (4:4:4).
- `ADDR_W`, 15: RAM address width.

Ports (clock and reset first):
- `clk_100MHz`  in  1: system clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `p_tick`  in  1: 25 MHz pixel tick, one cycle in four.
- `x`, `y`  in  10 each: current pixel position from the timing generator.
- `video_on`  in  1: high inside the display area.
- `wr_valid`  in  1: write request.
- `wr_ready`  out  1: write accepted when both `wr_valid` and `wr_ready` are high.
- `wr_addr`  in  ADDR_W: linear word address, computed as row*FB_W+col.
- `wr_data`  in  PIX_W: pixel value to write.
- `mem_en`, `mem_we`  out  1 each: RAM port controls.
- `mem_addr`  out  ADDR_W: RAM address.
- `mem_wdata`  out  PIX_W: RAM write data.
- `mem_rdata`  in  PIX_W: RAM read data, valid the cycle after `mem_en` with `mem_we` low.
- `rgb`  out  PIX_W: registered pixel output.
- `wr_oob`  out  1: sticky flag, out-of-range write dropped.
- `underrun`  out  1: sticky flag, display fetch missed its deadline.

## Operation
- **Trigger (cycle T):** a cycle with `p_tick`=1 and x[1:0]=0. On a trigger:
  - `cur_px` <= `next_px` (swap).
  - Compute the fetch target and latch `fetch_addr`.
  - Set `disp_pend`.
- **Fetch target:**
  - If x < HD-4: col = (x>>S)+1, row = y>>S.
  - Otherwise: col = 0, ny = (y==VMAX) ? 0 : y+1, row = (ny<VD) ? ny>>S : 0.
- **FSM states:**
  - IDLE.
  - RD_WAIT.
- **FSM transitions:**
  - IDLE with `disp_pend`: drive `mem_en`=1, `mem_we`=0, `mem_addr`=`fetch_addr`; clear `disp_pend`; go to RD_WAIT.
  - RD_WAIT: `next_px` <= `mem_rdata`; go to IDLE.
- **Write path:**
  - `wr_ready` = state==IDLE && !`disp_pend` && !trigger && `reset_n`.
  - On a handshake, in the same cycle (combinational): `mem_en`=1, `mem_we`=1, `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`.
- **Out-of-range write:** if `wr_addr` >= FB_W*FB_H, the write is still accepted but `mem_en` and `mem_we` stay 0 and `wr_oob` is set.
- **Pixel output**, on `p_tick` cycles only:
  - `rgb` <= !`video_on` ? 0 : (x[1:0]==0 ? `next_px` : `cur_px`).
  - `rgb` holds between ticks.
- **Underrun:** a trigger arriving while `disp_pend` or RD_WAIT is active sets `underrun`. The swap proceeds anyway with the stale `next_px`.
- **Idle bus:** in cycles with no RAM access, `mem_en`=`mem_we`=0 and `mem_addr`/`mem_wdata` are held.

## Timing
- **Reset values:** state=IDLE; `cur_px`, `next_px`, `fetch_addr`, `disp_pend` = 0; `rgb`=0; `wr_oob`=`underrun`=0; `wr_ready`=0 while `reset_n`=0.
- **Display fetch:** read issued at T+1, data captured at T+2.
  - `wr_ready` is low exactly in T, T+1 and T+2.
  - The next trigger is 16 cycles later, so `underrun` never sets in correct operation.
- **Write throughput:**
  - Writes are one cycle each, with no internal buffering.
  - Back-to-back writes are possible in every IDLE cycle without a pending fetch, i.e. 13 of every 16 cycles.
- **Simultaneous events:** a trigger arriving in the same cycle as `wr_valid` is resolved in favour of the trigger: `wr_ready`=0 and the write waits.
- **Stale data:** a write to the word already held in `next_px` is not displayed until that word is next fetched.
- **Reset mid-fetch:** abandons the read and returns to IDLE. The first post-reset trigger refetches.
- **Sticky flags:** cleared only by reset.

## Structure
- **Package `vga_pkg`** holds:
  - the timing constants HD, VD, HMAX=799, VMAX=524;
  - the framebuffer constants FB_W, FB_H, SCALE_SHIFT;
  - the FSM state typedef.
- **Sub-module `fb_addr_gen`** computes row*FB_W+col. This is shift-add for FB_W=160: (row<<7)+(row<<5)+col.

## Test plan
- **Reset:** hold `reset_n`=0 for 5 cycles -> `rgb`=0, `wr_ready`=0, `mem_en`=0, both flags 0.
- **Column upscale:** write addr 0=0xF00, addr 1=0x0F0, addr 160=0x00F, then run a frame -> `rgb`=0xF00 for x 0-3 / y 0-3; 0x0F0 for x 4-7; 0x00F for x 0-3 at y 4.
- **Contention:** hold `wr_valid`=1 continuously -> `wr_ready` low for exactly 3 cycles starting at each trigger; 13 writes per 16 cycles; `underrun` stays 0.
- **Out-of-range write:** write `wr_addr`=19200 -> handshake completes, no `mem_we`, `wr_oob`=1.
- **Blanking and frame wrap:** with `video_on`=0, `rgb`=0. At x=796, y=524 the fetch address is 0. At x=636, y=479 the fetch address is also 0, because row 120 is clamped to 0.
- **Reset mid-fetch:** assert `reset_n`=0 in RD_WAIT -> state IDLE, `next_px`=0. The next trigger fetches correctly and no flags are set.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing, framebuffer and FSM definitions for the VGA framebuffer arbiter.
package vga_pkg;
    localparam int HD          = 640;
    localparam int VD          = 480;
    localparam int HMAX        = 799;
    localparam int VMAX        = 524;
    localparam int FB_W        = 160;
    localparam int FB_H        = 120;
    localparam int SCALE_SHIFT = 2;
    localparam int PIX_W       = 12;
    localparam int ADDR_W      = 15;
    localparam int RC_W        = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-write request channel: valid/ready, accepted when both are high.
interface vga_fb_arbiter_if import vga_pkg::*; ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/fb_addr_gen.sv
// Linear framebuffer address row*FB_W+col; purely combinational.
module fb_addr_gen import vga_pkg::*; #(
    parameter int FB_WIDTH = FB_W,
    parameter int AW       = ADDR_W
) (
    input  logic [RC_W-1:0] row,
    input  logic [RC_W-1:0] col,
    output logic [AW-1:0]   addr
);
    generate
        if (FB_WIDTH == 160) begin : g_shift_add
            assign addr = (AW'(row) << 7) + (AW'(row) << 5) + AW'(col);
        end else begin : g_mult
            assign addr = AW'(row) * AW'(FB_WIDTH) + AW'(col);
        end
    endgenerate
endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between display prefetch (fixed priority) and pixel writes.
// Fetch issues T+1, data lands T+2; wr_ready drops for T..T+2 of each 16-cycle fetch slot, writes are unbuffered.
module vga_fb_arbiter import vga_pkg::*; #(
    parameter int FB_WIDTH  = FB_W,
    parameter int FB_HEIGHT = FB_H,
    parameter int SHIFT     = SCALE_SHIFT
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    input  logic              p_tick,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              video_on,
    vga_fb_arbiter_if.slave   wr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  rgb,
    output logic              wr_oob,
    underrun
);
    localparam logic [9:0]        X_LAST_COL = 10'(HD - 4);
    localparam logic [9:0]        Y_LAST     = 10'(VMAX);
    localparam logic [9:0]        Y_DISP     = 10'(VD);
    localparam logic [ADDR_W-1:0] FB_WORDS   = ADDR_W'(FB_WIDTH * FB_HEIGHT);

    arb_state_t        state, state_nxt;
    logic [PIX_W-1:0]  cur_px, next_px;
    logic [ADDR_W-1:0] fetch_addr, fetch_target;
    logic              disp_pend;
    logic [ADDR_W-1:0] addr_q;
    logic [PIX_W-1:0]  wdata_q;

    logic              trigger;
    logic              rd_issue, rd_capture, ready, hs, oob, wr_commit;
    logic [9:0]        ny;
    logic [RC_W-1:0]   row, col;

    assign trigger = p_tick && (x[1:0] == 2'b00);
    assign oob     = (wr.wr_addr >= FB_WORDS);

    // Prefetch the word needed four pixels ahead; the last group of a line fetches col 0 of the next line.
    always_comb begin
        ny  = '0;
        row = '0;
        col = '0;
        if (x < X_LAST_COL) begin
            col = RC_W'(x >> SHIFT) + RC_W'(1);
            row = RC_W'(y >> SHIFT);
        end else begin
            ny  = (y == Y_LAST) ? 10'd0 : y + 10'd1;
            row = (ny < Y_DISP) ? RC_W'(ny >> SHIFT) : '0;
        end
    end

    fb_addr_gen #(.FB_WIDTH(FB_WIDTH), .AW(ADDR_W)) u_addr_gen (
        .row  (row),
        .col  (col),
        .addr (fetch_target)
    );

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (disp_pend) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_issue    = reset_n && (state == IDLE) && disp_pend;
        rd_capture  = (state == RD_WAIT);
        ready       = (state == IDLE) && !disp_pend && !trigger && reset_n;
        hs          = wr.wr_valid && ready;
        wr_commit   = hs && !oob;
        wr.wr_ready = ready;
        mem_en      = rd_issue || wr_commit;
        mem_we      = wr_commit;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        if (rd_issue) begin
            mem_addr = fetch_addr;
        end else if (wr_commit) begin
            mem_addr  = wr.wr_addr;
            mem_wdata = wr.wr_data;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            cur_px     <= '0;
            next_px    <= '0;
            fetch_addr <= '0;
            disp_pend  <= 1'b0;
            rgb        <= '0;
            wr_oob     <= 1'b0;
            underrun   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            if (trigger) begin
                cur_px     <= next_px;
                fetch_addr <= fetch_target;
                disp_pend  <= 1'b1;
                if (disp_pend || state == RD_WAIT) underrun <= 1'b1;
            end else if (rd_issue) begin
                disp_pend <= 1'b0;
            end
            if (rd_capture) next_px <= mem_rdata;
            if (mem_en) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (hs && oob) wr_oob <= 1'b1;
            // First pixel of a group shows the word just swapped in, which is still in next_px.
            if (p_tick) rgb <= video_on ? ((x[1:0] == 2'b00) ? next_px : cur_px) : '0;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a RAM model and shadow-framebuffer scoreboard.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    logic              clk_100MHz = 1'b0;
    logic              reset_n;
    logic              p_tick;
    logic [9:0]        x, y;
    logic              video_on;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;
    logic [PIX_W-1:0]  rgb;
    logic              wr_oob, underrun;

    vga_fb_arbiter_if wif ();

    vga_fb_arbiter dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .p_tick     (p_tick),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .wr         (wif.slave),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rgb        (rgb),
        .wr_oob     (wr_oob),
        .underrun   (underrun)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    logic [PIX_W-1:0] ram [0:32767];
    always @(posedge clk_100MHz) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    logic [PIX_W-1:0] shadow [0:19199];
    logic [PIX_W-1:0] exp_q [$];
    int  vectors = 0;
    int  miscompares = 0;
    int  since_trig = 1000;
    int  nhs = 0;
    bit  chk_ready = 0;
    bit  auto_inc = 0;
    bit  last_hs = 0;
    bit  we_at_hs = 0;
    logic [31:0] last_rd = 32'hFFFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, observe the handshake and RAM bus before the edge, score rgb after it.
    task automatic cyc(input bit tick, input int xi, input int yi, input bit von, input int ovr);
        logic [PIX_W-1:0] e;
        int idx;
        p_tick   = tick;
        x        = 10'(xi);
        y        = 10'(yi);
        video_on = von;
        if (tick && (xi % 4 == 0)) since_trig = 0;
        else if (since_trig < 1000) since_trig++;
        #1;
        last_hs  = wif.wr_valid && wif.wr_ready;
        we_at_hs = last_hs && mem_en && mem_we;
        if (mem_en && !mem_we) last_rd = 32'(mem_addr);
        if (chk_ready) chk("wr_ready_slot", 32'(wif.wr_ready), 32'(since_trig >= 3));
        if (last_hs) begin
            nhs++;
            if (wif.wr_addr < 15'd19200) shadow[wif.wr_addr] = wif.wr_data;
        end
        if (tick) begin
            idx = (yi / 4) * 160 + (xi / 4);
            if (ovr >= 0)  exp_q.push_back(12'(ovr));
            else if (!von) exp_q.push_back(12'h000);
            else           exp_q.push_back(shadow[idx]);
        end
        @(posedge clk_100MHz);
        #1;
        if (last_hs && auto_inc) wif.wr_addr = wif.wr_addr + 15'd1;
        if (tick) begin
            e = exp_q.pop_front();
            chk("rgb", 32'(rgb), 32'(e));
        end
    endtask

    task automatic pix(input int xi, input int yi, input bit von, input int ovr);
        cyc(1, xi, yi, von, ovr);
        for (int k = 0; k < 3; k++) cyc(0, xi, yi, von, -1);
    endtask

    task automatic scan_line(input int yi, input int nx);
        int py;
        py = (yi == 0) ? 524 : yi - 1;
        for (int xx = 796; xx < 800; xx++) pix(xx, py, 0, -1);
        for (int xx = 0; xx < nx; xx++) pix(xx, yi, 1, -1);
    endtask

    task automatic wr(input int a, input int d);
        bit done;
        done = 0;
        wif.wr_valid = 1'b1;
        wif.wr_addr  = 15'(a);
        wif.wr_data  = 12'(d);
        for (int i = 0; i < 20 && !done; i++) begin
            cyc(0, 0, 0, 0, -1);
            done = last_hs;
        end
        wif.wr_valid = 1'b0;
        chk("wr_handshake", 32'(done), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = '0;
        for (int i = 0; i < 19200; i++) shadow[i] = '0;
        reset_n      = 1'b0;
        p_tick       = 1'b0;
        x            = '0;
        y            = '0;
        video_on     = 1'b0;
        wif.wr_valid = 1'b1;
        wif.wr_addr  = '0;
        wif.wr_data  = '0;
        @(posedge clk_100MHz);
        #1;

        // Reset: requests must be refused and the RAM left alone.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, -1);
            chk("rst_wr_ready", 32'(wif.wr_ready), 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
        end
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_wr_oob", 32'(wr_oob), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        wif.wr_valid = 1'b0;
        reset_n      = 1'b1;
        cyc(0, 0, 0, 0, -1);
        wif.wr_valid = 1'b1;
        #1;
        chk("idle_wr_ready", 32'(wif.wr_ready), 32'd1);
        wif.wr_valid = 1'b0;

        // Column and row upscale.
        wr(0, 12'hF00);
        wr(1, 12'h0F0);
        wr(160, 12'h00F);
        for (int yy = 0; yy < 5; yy++) scan_line(yy, 16);

        // Contention: continuous write pressure while scanning.
        wif.wr_valid = 1'b1;
        wif.wr_addr  = 15'd12000;
        wif.wr_data  = 12'h5A5;
        auto_inc     = 1;
        chk_ready    = 1;
        for (int xx = 796; xx < 800; xx++) pix(xx, 524, 0, -1);
        nhs = 0;
        for (int xx = 0; xx < 32; xx++) pix(xx, 0, 1, -1);
        chk("writes_per_8_slots", 32'(nhs), 32'd104);
        chk_ready    = 0;
        auto_inc     = 0;
        wif.wr_valid = 1'b0;
        chk("contention_underrun", 32'(underrun), 32'd0);
        chk("contention_ram", 32'(ram[12000]), 32'h5A5);

        // Fetch targets at the line and frame boundaries.
        last_rd = 32'hFFFF; pix(796, 524, 0, -1); chk("fetch_frame_wrap", last_rd, 32'd0);
        last_rd = 32'hFFFF; pix(636, 479, 0, -1); chk("fetch_row_clamp", last_rd, 32'd0);
        last_rd = 32'hFFFF; pix(636, 100, 0, -1); chk("fetch_next_line", last_rd, 32'd4000);
        last_rd = 32'hFFFF; pix(4, 10, 0, -1);    chk("fetch_mid_line", last_rd, 32'd322);

        // Last in-range word vs first out-of-range word.
        wr(19199, 12'hABC);
        chk("last_word_we", 32'(we_at_hs), 32'd1);
        chk("last_word_oob", 32'(wr_oob), 32'd0);
        wr(19200, 12'h123);
        chk("oob_we", 32'(we_at_hs), 32'd0);
        chk("oob_flag", 32'(wr_oob), 32'd1);
        cyc(0, 0, 0, 0, -1);
        chk("oob_sticky", 32'(wr_oob), 32'd1);

        // Reset while the read of word 0 (0xF00) is in flight.
        cyc(1, 796, 524, 0, -1);
        cyc(0, 796, 524, 0, -1);
        reset_n = 1'b0;
        cyc(0, 796, 524, 0, -1);
        reset_n = 1'b1;
        wif.wr_valid = 1'b1;
        wif.wr_addr  = 15'd15000;
        #1;
        chk("post_rst_idle", 32'(wif.wr_ready), 32'd1);
        wif.wr_valid = 1'b0;
        cyc(0, 796, 524, 0, -1);
        cyc(0, 796, 524, 0, -1);
        for (int xx = 0; xx < 4; xx++) pix(xx, 0, 1, 0);
        for (int xx = 4; xx < 8; xx++) pix(xx, 0, 1, -1);
        pix(8, 0, 0, -1);
        chk("post_rst_oob", 32'(wr_oob), 32'd0);
        chk("post_rst_underrun", 32'(underrun), 32'd0);

        // Two triggers in adjacent cycles must flag an underrun.
        cyc(1, 0, 0, 0, -1);
        cyc(1, 0, 0, 0, -1);
        chk("underrun_set", 32'(underrun), 32'd1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, -1);
        chk("underrun_sticky", 32'(underrun), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
